// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys read
// from an external pre-expanded key store through an index/data port.
module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_e;

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  // Entry b lives at bits [2047-8b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    end
    return o;
  endfunction

  // Row r of the output takes column (c - r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a  [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 32 * c - 8 * r -: 8];
        x2[r] = xtime(a[r]);
        x4[r] = xtime(x2[r]);
        x8[r] = xtime(x4[r]);
      end
      // b_r = 0e*a_r ^ 0b*a_r+1 ^ 0d*a_r+2 ^ 09*a_r+3 (indices mod 4)
      for (int r = 0; r < 4; r++) begin
        o[127 - 32 * c - 8 * r -: 8] =
            (x8[r] ^ x4[r] ^ x2[r]) ^
            (x8[(r + 1) % 4] ^ x2[(r + 1) % 4] ^ a[(r + 1) % 4]) ^
            (x8[(r + 2) % 4] ^ x4[(r + 2) % 4] ^ a[(r + 2) % 4]) ^
            (x8[(r + 3) % 4] ^ a[(r + 3) % 4]);
      end
    end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] isb_s;
  logic [127:0] imc_s;

  // Shared round datapath: InvShiftRows -> InvSubBytes, then key add and InvMixColumns.
  always_comb begin
    isb_s = inv_sub_bytes(inv_shift_rows(data_q));
    imc_s = inv_mix_columns(isb_s ^ rk_data);
  end

  // Next-state, round counter and data path selection.
  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    data_d = data_q;
    pt_d   = pt_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = ct_in ^ rk_data;
          rnd_d  = NR_M1;
          fsm_d  = S_ROUND;
        end else begin
          fsm_d  = S_IDLE;
        end
      end
      S_ROUND: begin
        data_d = imc_s;
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          fsm_d = S_FINAL;
        end else begin
          fsm_d = S_ROUND;
        end
      end
      S_FINAL: begin
        data_d = isb_s ^ rk_data;
        pt_d   = isb_s ^ rk_data;
        fsm_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
        end else begin
          fsm_d = S_DONE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      rnd_q  <= 4'd0;
      data_q <= 128'd0;
      pt_q   <= 128'd0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
      pt_q   <= pt_d;
    end
  end

  // Handshake and key-index decode, purely from registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = NR_IDX;
    case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = rnd_q;
      end
      S_FINAL: begin
        busy   = 1'b1;
        rk_idx = 4'd0;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        rk_idx = NR_IDX;
      end
    endcase
  end

  assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: reference AES-128 encryptor built from
// GF(2^8) arithmetic produces ciphertexts, expected plaintexts go through a queue.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;

  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_t [16];

  always #5 clk = ~clk;

  assign rk_data = rk_t[rk_idx];

  aes_inv_cipher #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ct_in(ct_in),
    .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid), .out_ready(out_ready),
    .pt_out(pt_out), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from multiplicative inverse plus affine map, then key expansion.
  task automatic build_tables();
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32 * i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'd0};
        rcon = xt(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_t[r] = 128'd0;
    for (int r = 0; r < 11; r++) rk_t[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_t[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[127 - 8 * i -: 8] = sbox_t[s[127 - 8 * i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[127 - 8 * (4 * c + q) -: 8] = t[127 - 8 * (4 * ((c + q) % 4) + q) -: 8];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127 - 32 * c -: 8];
          a1 = s[119 - 32 * c -: 8];
          a2 = s[111 - 32 * c -: 8];
          a3 = s[103 - 32 * c -: 8];
          s[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rk_t[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus only: waits for in_ready, offers one block for one cycle, queues the expected plaintext.
  task automatic send_block(input logic [127:0] pt, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (in_ready) begin
      in_valid = 1'b1;
      ct_in    = enc(pt);
      exp_q.push_back(pt);
      @(negedge clk);
      in_valid = 1'b0;
      ct_in    = rnd128();
      ok       = 1'b1;
    end
  endtask

  task automatic wait_out(output int n, output bit ok);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct_in = 128'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (pt_out !== 128'd0) begin n_bad++; $display("FAIL reset_pt_out got=%h exp=0", pt_out); end
    n_cmp++; if (rk_idx !== 4'd10) begin n_bad++; $display("FAIL reset_rk_idx got=%0d exp=10", rk_idx); end
  endtask

  // FIPS-197 C.1 with fixed constants; checks rk_idx every cycle and the latency.
  task automatic test_c1_rk_sequence();
    logic [3:0]   er;
    logic [127:0] e;
    out_ready = 1'b1;
    n_cmp++; if (rk_t[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_bad++; $display("FAIL keystore_rk10 got=%h exp=13111d7fe3944a17f307a78b4d2b30c5", rk_t[10]); end
    n_cmp++; if (rk_idx !== 4'd10) begin n_bad++; $display("FAIL c1_rk_accept got=%0d exp=10", rk_idx); end
    in_valid = 1'b1;
    ct_in    = C1_CT;
    exp_q.push_back(C1_PT);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin in_valid = 1'b0; ct_in = rnd128(); end
      if (k <= 10) begin
        er = (k <= 9) ? 4'(10 - k) : 4'd0;
        n_cmp++; if (rk_idx !== er) begin n_bad++; $display("FAIL c1_rk_idx k=%0d got=%0d exp=%0d", k, rk_idx, er); end
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL c1_early k=%0d out_valid=%b busy=%b exp 0/1", k, out_valid, busy); end
      end else if (k == 11) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL c1_latency out_valid=%b exp=1 at 10 cycles", out_valid); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL c1_pt queue empty got=%h", pt_out); end
        else begin
          e = exp_q.pop_front();
          if (pt_out !== e) begin n_bad++; $display("FAIL c1_pt got=%h exp=%h", pt_out, e); end
        end
      end else begin
        n_cmp++; if (rk_idx !== 4'd10 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL c1_back_idle rk_idx=%0d in_ready=%b out_valid=%b exp 10/1/0", rk_idx, in_ready, out_valid); end
        n_cmp++; if (pt_out !== C1_PT) begin n_bad++; $display("FAIL c1_pt_hold got=%h exp=%h", pt_out, C1_PT); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit           ok;
    int           n;
    logic [127:0] e;
    out_ready = 1'b0;
    send_block(rnd128(), ok);
    wait_out(n, ok);
    n_cmp++; if (!ok || n != 10) begin n_bad++; $display("FAIL bp_latency ok=%b cycles=%0d exp=10", ok, n); end
    e = (exp_q.size() != 0) ? exp_q[0] : 128'd0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold i=%0d out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready); end
      n_cmp++; if (pt_out !== e) begin n_bad++; $display("FAIL bp_pt i=%0d got=%h exp=%h", i, pt_out, e); end
      in_valid = 1'b1;
      ct_in    = rnd128();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_final queue empty got=%h", pt_out); end
    else begin
      e = exp_q.pop_front();
      if (pt_out !== e) begin n_bad++; $display("FAIL bp_final got=%h exp=%h", pt_out, e); end
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    n_cmp++; if (pt_out !== e) begin n_bad++; $display("FAIL bp_pt_after got=%h exp=%h", pt_out, e); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_no_accept busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int           acc_t [2];
    int           n_acc;
    int           n_out;
    logic [127:0] e;
    acc_t[0] = 0; acc_t[1] = 0; n_acc = 0; n_out = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ct_in     = C1_CT;
    for (int i = 0; i < 60 && n_out < 2; i++) begin
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_pt queue empty got=%h", pt_out); end
        else begin
          e = exp_q.pop_front();
          if (pt_out !== e) begin n_bad++; $display("FAIL b2b_pt #%0d got=%h exp=%h", n_out, pt_out, e); end
        end
        n_out++;
      end
      if (in_ready && in_valid) begin
        if (n_acc < 2) acc_t[n_acc] = i;
        n_acc++;
        exp_q.push_back(C1_PT);
      end else if (n_acc >= 2) begin
        in_valid = 1'b0;
      end
      if (n_out < 2) @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (n_out != 2 || n_acc != 2) begin n_bad++; $display("FAIL b2b_count outputs=%0d accepts=%0d exp 2/2", n_out, n_acc); end
    n_cmp++; if (acc_t[1] - acc_t[0] != 12) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=12", acc_t[1] - acc_t[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit           ok;
    int           n;
    logic [127:0] e;
    out_ready = 1'b1;
    send_block(C1_PT, ok);
    n = 0;
    while (!(busy === 1'b1 && rk_idx === 4'd5) && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (rk_idx !== 4'd5 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach rk_idx=%0d busy=%b exp 5/1", rk_idx, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctrl in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    n_cmp++; if (pt_out !== 128'd0) begin n_bad++; $display("FAIL rst_mid_pt got=%h exp=0", pt_out); end
    n_cmp++; if (rk_idx !== 4'd10) begin n_bad++; $display("FAIL rst_mid_rk got=%0d exp=10", rk_idx); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_abort out_valid=%b busy=%b exp 0/0", out_valid, busy); end
    send_block(C1_PT, ok);
    wait_out(n, ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL rst_mid_after no output got=%h", pt_out); end
    else begin
      e = exp_q.pop_front();
      if (pt_out !== e) begin n_bad++; $display("FAIL rst_mid_after got=%h exp=%h", pt_out, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_input();
    bit           ok;
    int           n;
    logic [127:0] e;
    out_ready = 1'b1;
    send_block(rnd128(), ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ign_in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b1;
    ct_in    = rnd128();
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n, ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL ign_pt no output got=%h", pt_out); end
    else begin
      e = exp_q.pop_front();
      if (pt_out !== e) begin n_bad++; $display("FAIL ign_pt got=%h exp=%h", pt_out, e); end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ign_phantom busy=%b out_valid=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_random();
    bit           ok;
    int           n;
    logic [127:0] e;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send_block(rnd128(), ok);
      wait_out(n, ok);
      n_cmp++; if (!ok || n != 10) begin n_bad++; $display("FAIL rand_latency #%0d ok=%b cycles=%0d exp=10", j, ok, n); end
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL rand_pt #%0d queue empty got=%h", j, pt_out); end
      else begin
        e = exp_q.pop_front();
        if (pt_out !== e) begin n_bad++; $display("FAIL rand_pt #%0d got=%h exp=%h", j, pt_out, e); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_c1_rk_sequence();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignored_input();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
